// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame state encoding and the data width.
// The receiver and transmitter both import this package.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// It resets to 1, which is the idle level of a UART line.
module uart_sync (
  input  logic clk,
  input  logic rst_,
  input  logic d,
  output logic q
);

  logic meta;

  // Bring the async input into the clk domain through two flops.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (idle-high, LSB first).
// The start bit is validated at mid-bit, and each data bit and the stop bit are
// sampled at their mid-point. A good frame gives a one-cycle rx_valid pulse.
// A low stop bit gives a one-cycle rx_frame_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   rx_serial,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_frame_err,
  output logic                   rx_busy
);

  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = DIVISOR / 2;

  localparam logic [31:0] BIT_LAST  = 32'(DIVISOR - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

  uart_state_t            state;
  logic                   rx_s;
  logic                   prev;
  logic [31:0]            baud_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shifter;

  uart_sync u_sync (
    .clk  (clk),
    .rst_ (rst_),
    .d    (rx_serial),
    .q    (rx_s)
  );

  // Delay the synchronised line by one cycle so a falling edge can be detected.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev <= 1'b1;
    end else begin
      prev <= rx_s;
    end
  end

  // Frame FSM: tracks mid-bit timing, shifts in data and drives the registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shifter      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (prev && !rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end

        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shifter  <= {rx_s, shifter[UART_DATA_W-1:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end

        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            rx_busy  <= 1'b0;
            if (rx_s) begin
              rx_data  <= shifter;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at DIVISOR=10 and HALF=5.
// The bench drives the serial line itself, acting as the transmitter.
module tb_uart_rx;

  localparam int BIT = 10;

  logic       clk;
  logic       rst_;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int total;
  int bad;
  int cyc;
  int valid_cnt;
  int err_cnt;
  int both_cnt;
  int busy_seen;
  int valid_cyc;
  logic [7:0] got_q[$];

  uart_rx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk          (clk),
    .rst_         (rst_),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count posedges so that pulse latency can be measured.
  always @(posedge clk) cyc <= cyc + 1;

  // Record pulses and busy activity on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_) begin
      if (rx_valid) begin
        valid_cnt = valid_cnt + 1;
        valid_cyc = cyc;
        got_q.push_back(rx_data);
      end
      if (rx_frame_err) err_cnt = err_cnt + 1;
      if (rx_valid && rx_frame_err) both_cnt = both_cnt + 1;
      if (rx_busy) busy_seen = 1;
    end
  end

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    busy_seen = 0;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst_      = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", rx_valid); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", rx_frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", rx_busy); end
    rst_ = 1'b1;
    idle(20);
  endtask

  task automatic test_loopback();
    int start_cyc;
    clear_counts();
    start_cyc = cyc;
    send_byte(8'hA5, 1'b1);
    idle(20);
    total++; if (valid_cnt !== 1) begin bad++; $display("[TB] FAIL loop_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("[TB] FAIL loop_data got=%h want=a5", rx_data); end
    total++; if (err_cnt !== 0) begin bad++; $display("[TB] FAIL loop_err_cnt got=%0d want=0", err_cnt); end
    total++; if (busy_seen !== 1) begin bad++; $display("[TB] FAIL loop_busy_seen got=%0d want=1", busy_seen); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL loop_busy_end got=%b want=0", rx_busy); end
    total++;
    if ((valid_cyc - start_cyc) < 97 || (valid_cyc - start_cyc) > 99) begin
      bad++; $display("[TB] FAIL loop_latency got=%0d want=97..99", valid_cyc - start_cyc);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    total++; if (valid_cnt !== 2) begin bad++; $display("[TB] FAIL b2b_valid_cnt got=%0d want=2", valid_cnt); end
    total++;
    if (got_q.size() < 1 || got_q[0] !== 8'h00) begin
      bad++; $display("[TB] FAIL b2b_first got=%h want=00", (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    total++;
    if (got_q.size() < 2 || got_q[1] !== 8'hFF) begin
      bad++; $display("[TB] FAIL b2b_second got=%h want=ff", (got_q.size() > 1) ? got_q[1] : 8'hxx);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    rx_serial = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    total++; if (valid_cnt !== 0) begin bad++; $display("[TB] FAIL glitch_valid got=%0d want=0", valid_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("[TB] FAIL glitch_err got=%0d want=0", err_cnt); end
    total++; if (busy_seen !== 1) begin bad++; $display("[TB] FAIL glitch_busy_seen got=%0d want=1", busy_seen); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_end got=%b want=0", rx_busy); end
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_byte(8'h11, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(30);
    total++; if (valid_cnt !== 1) begin bad++; $display("[TB] FAIL ferr_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (err_cnt !== 1) begin bad++; $display("[TB] FAIL ferr_err_cnt got=%0d want=1", err_cnt); end
    total++; if (rx_data !== 8'h11) begin bad++; $display("[TB] FAIL ferr_data got=%h want=11", rx_data); end
    total++; if (both_cnt !== 0) begin bad++; $display("[TB] FAIL ferr_exclusive got=%0d want=0", both_cnt); end
  endtask

  task automatic test_break();
    clear_counts();
    rx_serial = 1'b0;
    repeat (30 * BIT) @(posedge clk);
    #1;
    idle(30);
    send_byte(8'h7E, 1'b1);
    idle(20);
    total++; if (err_cnt !== 1) begin bad++; $display("[TB] FAIL break_err_cnt got=%0d want=1", err_cnt); end
    total++; if (valid_cnt !== 1) begin bad++; $display("[TB] FAIL break_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (rx_data !== 8'h7E) begin bad++; $display("[TB] FAIL break_data got=%h want=7e", rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hC3;
    clear_counts();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx_serial = b[4];
    repeat (5) @(posedge clk);
    #1;
    rst_      = 1'b0;
    rx_serial = 1'b1;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data got=%h want=00", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", rx_busy); end
    total++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_pulses got=%b%b want=00", rx_valid, rx_frame_err);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b1;
    clear_counts();
    idle(20);
    send_byte(8'h5A, 1'b1);
    idle(20);
    total++; if (valid_cnt !== 1) begin bad++; $display("[TB] FAIL rstmid_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("[TB] FAIL rstmid_after_data got=%h want=5a", rx_data); end
    total++; if (err_cnt !== 0) begin bad++; $display("[TB] FAIL rstmid_err_cnt got=%0d want=0", err_cnt); end
  endtask

  // Run each scenario in order, then report the totals.
  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    valid_cyc = 0;
    clear_counts();
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
